// File: rtl/chess_pkg.sv
// Shared definitions for the move-commit controller: piece codes, FSM states,
// the starting position and piece ownership helpers.
package chess_pkg;

   localparam logic [3:0] P_EMPTY  = 4'd0;
   localparam logic [3:0] W_PAWN   = 4'd1;
   localparam logic [3:0] W_BISHOP = 4'd2;
   localparam logic [3:0] W_KNIGHT = 4'd3;
   localparam logic [3:0] W_ROOK   = 4'd4;
   localparam logic [3:0] W_QUEEN  = 4'd5;
   localparam logic [3:0] W_KING   = 4'd6;
   localparam logic [3:0] B_PAWN   = 4'd7;
   localparam logic [3:0] B_BISHOP = 4'd8;
   localparam logic [3:0] B_KNIGHT = 4'd9;
   localparam logic [3:0] B_ROOK   = 4'd10;
   localparam logic [3:0] B_QUEEN  = 4'd11;
   localparam logic [3:0] B_KING   = 4'd12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_ARMED,
      ST_CLEAR_SRC,
      ST_WRITE_DST
   } state_t;

   // Back-rank layout for one side, indexed by column.
   function automatic logic [3:0] back_rank(input logic [2:0] col, input logic black);
      logic [3:0] p;
      case (col)
         3'd0, 3'd7: p = black ? B_ROOK   : W_ROOK;
         3'd1, 3'd6: p = black ? B_KNIGHT : W_KNIGHT;
         3'd2, 3'd5: p = black ? B_BISHOP : W_BISHOP;
         3'd3:       p = black ? B_QUEEN  : W_QUEEN;
         default:    p = black ? B_KING   : W_KING;
      endcase
      return p;
   endfunction

   function automatic logic [255:0] init_board();
      logic [255:0] b;
      b = '0;
      for (int c = 0; c < 8; c++) begin
         b[4*c      +: 4] = back_rank(3'(c), 1'b0);
         b[4*(8+c)  +: 4] = W_PAWN;
         b[4*(48+c) +: 4] = B_PAWN;
         b[4*(56+c) +: 4] = back_rank(3'(c), 1'b1);
      end
      return b;
   endfunction

   localparam logic [255:0] INIT_BOARD = init_board();

   function automatic logic is_side(input logic [3:0] piece, input logic side);
      if (side)
         return (piece >= B_PAWN) && (piece <= B_KING);
      else
         return (piece >= W_PAWN) && (piece <= W_KING);
   endfunction

   // Codes 13..15 are not pieces and read back as empty.
   function automatic logic [3:0] norm_piece(input logic [3:0] piece);
      return (piece > B_KING) ? P_EMPTY : piece;
   endfunction

endpackage

// File: rtl/board_regfile.sv
// 64-square board store: one write port, whole board visible as a flat vector.
// Reset reloads the starting position and overrides any write in that cycle.
module board_regfile
   import chess_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [5:0]   waddr,
   input  logic [3:0]   wdata,
   output logic [255:0] board_flat
);

   logic [3:0] cells [64];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++)
            cells[i] <= INIT_BOARD[4*i +: 4];
      end else if (we) begin
         cells[waddr] <= wdata;
      end
   end

   for (genvar g = 0; g < 64; g++) begin : g_flat
      assign board_flat[4*g +: 4] = cells[g];
   end

endmodule

// File: rtl/move_commit_ctrl.sv
// Click-driven move controller: select a piece, validate the target against
// the latched move mask, then commit the move as two single-square writes.
module move_commit_ctrl
   import chess_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         click_valid,
   input  logic [5:0]   click_pos,
   output logic         click_ready,
   output logic [3:0]   sel_figure,
   output logic [5:0]   sel_pos,
   input  logic [63:0]  possible_moves,
   output logic [255:0] board_flat,
   output logic         turn,
   output logic         move_done,
   output logic         move_illegal,
   output logic [3:0]   captured_piece
);

   state_t      state, state_nxt;
   logic [63:0] mask;
   logic [5:0]  dest;
   logic        illegal_q;

   logic        we;
   logic [5:0]  waddr;
   logic [3:0]  wdata;

   logic [3:0]  click_piece;
   logic [3:0]  dest_piece;
   logic        click_own;
   logic        do_select;
   logic        do_deselect;
   logic        do_accept;
   logic        do_illegal;

   board_regfile u_board (
      .clk        (clk),
      .rst        (rst),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .board_flat (board_flat)
   );

   assign click_piece = board_flat[{click_pos, 2'b00} +: 4];
   assign dest_piece  = board_flat[{dest, 2'b00} +: 4];
   assign click_own   = is_side(click_piece, turn);

   always_comb begin
      state_nxt   = state;
      we          = 1'b0;
      waddr       = sel_pos;
      wdata       = P_EMPTY;
      do_select   = 1'b0;
      do_deselect = 1'b0;
      do_accept   = 1'b0;
      do_illegal  = 1'b0;
      click_ready = 1'b0;
      move_done   = 1'b0;

      case (state)
         ST_IDLE: begin
            click_ready = 1'b1;
            if (click_valid && click_own) begin
               do_select = 1'b1;
               state_nxt = ST_SELECT;
            end
         end

         ST_SELECT: begin
            state_nxt = ST_ARMED;
         end

         // Priority: deselect, reselect own piece, legal target, else reject.
         ST_ARMED: begin
            click_ready = 1'b1;
            if (click_valid) begin
               if (click_pos == sel_pos) begin
                  do_deselect = 1'b1;
                  state_nxt   = ST_IDLE;
               end else if (click_own) begin
                  do_select = 1'b1;
                  state_nxt = ST_SELECT;
               end else if (mask[click_pos]) begin
                  do_accept = 1'b1;
                  state_nxt = ST_CLEAR_SRC;
               end else begin
                  do_illegal = 1'b1;
               end
            end
         end

         ST_CLEAR_SRC: begin
            we        = 1'b1;
            waddr     = sel_pos;
            wdata     = P_EMPTY;
            state_nxt = ST_WRITE_DST;
         end

         ST_WRITE_DST: begin
            we        = 1'b1;
            waddr     = dest;
            wdata     = sel_figure;
            move_done = 1'b1;
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign move_illegal = illegal_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         turn           <= 1'b0;
         illegal_q      <= 1'b0;
         captured_piece <= P_EMPTY;
         sel_figure     <= P_EMPTY;
         sel_pos        <= '0;
         mask           <= '0;
         dest           <= '0;
      end else begin
         state     <= state_nxt;
         illegal_q <= do_illegal;

         if (do_select) begin
            sel_pos    <= click_pos;
            sel_figure <= click_piece;
         end
         if (do_deselect) begin
            sel_pos    <= '0;
            sel_figure <= P_EMPTY;
            mask       <= '0;
         end
         // The generator has seen the new selection for a full cycle here.
         if (state == ST_SELECT)
            mask <= possible_moves;
         if (do_accept)
            dest <= click_pos;
         if (state == ST_CLEAR_SRC)
            captured_piece <= norm_piece(dest_piece);
         if (state == ST_WRITE_DST) begin
            turn       <= ~turn;
            sel_pos    <= '0;
            sel_figure <= P_EMPTY;
            mask       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_move_commit_ctrl.sv
// Scoreboard bench for move_commit_ctrl: a rule-level game model predicts
// pulses and board contents; a monitor checks every pulse the DUT raises.
module tb_move_commit_ctrl;

   logic         clk;
   logic         rst;
   logic         click_valid;
   logic [5:0]   click_pos;
   logic         click_ready;
   logic [3:0]   sel_figure;
   logic [5:0]   sel_pos;
   logic [63:0]  possible_moves;
   logic [255:0] board_flat;
   logic         turn;
   logic         move_done;
   logic         move_illegal;
   logic [3:0]   captured_piece;

   move_commit_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .click_valid    (click_valid),
      .click_pos      (click_pos),
      .click_ready    (click_ready),
      .sel_figure     (sel_figure),
      .sel_pos        (sel_pos),
      .possible_moves (possible_moves),
      .board_flat     (board_flat),
      .turn           (turn),
      .move_done      (move_done),
      .move_illegal   (move_illegal),
      .captured_piece (captured_piece)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in move generator: a per-square target table.
   logic [63:0] mask_tab [64];
   assign possible_moves = mask_tab[sel_pos];

   logic [255:0] tb_init =
      256'hA98CB89A_77777777_00000000_00000000_00000000_00000000_11111111_43265234;

   typedef struct {
      bit           is_done;
      int           cyc;
      logic [255:0] board;
      logic         turn;
      logic [3:0]   cap;
   } exp_t;

   exp_t expq[$];

   logic [3:0] mboard [64];
   logic       mturn;
   bit         msel_v;
   int         msel;

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit own(input logic [3:0] p, input logic t);
      return t ? (p >= 4'd7 && p <= 4'd12) : (p >= 4'd1 && p <= 4'd6);
   endfunction

   function automatic logic [255:0] model_flat();
      logic [255:0] b;
      for (int i = 0; i < 64; i++) b[4*i +: 4] = mboard[i];
      return b;
   endfunction

   function automatic logic [3:0] sq(input int n);
      return board_flat[4*n +: 4];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) mboard[i] = tb_init[4*i +: 4];
      mturn  = 1'b0;
      msel_v = 1'b0;
      msel   = 0;
   endfunction

   // Kinds: 0 dropped, 1 select, 2 deselect, 3 move, 4 illegal.
   function automatic int model_click(input int pos, input int dcyc);
      exp_t e;
      int kind = 0;
      if (!msel_v) begin
         if (own(mboard[pos], mturn)) begin
            msel_v = 1'b1; msel = pos; kind = 1;
         end
      end else if (pos == msel) begin
         msel_v = 1'b0; kind = 2;
      end else if (own(mboard[pos], mturn)) begin
         msel = pos; kind = 1;
      end else if (mask_tab[msel][pos]) begin
         e.cap        = (mboard[pos] > 4'd12) ? 4'd0 : mboard[pos];
         mboard[pos]  = mboard[msel];
         mboard[msel] = 4'd0;
         mturn        = ~mturn;
         msel_v       = 1'b0;
         e.is_done = 1'b1; e.cyc = dcyc + 2; e.board = model_flat(); e.turn = mturn;
         expq.push_back(e);
         kind = 3;
      end else begin
         e.is_done = 1'b0; e.cyc = dcyc + 1; e.board = model_flat(); e.turn = mturn;
         e.cap = 4'd0;
         expq.push_back(e);
         kind = 4;
      end
      return kind;
   endfunction

   // Called at a negedge; returns at the following negedge.
   task automatic do_click(input int pos, output int kind);
      click_valid = 1'b1;
      click_pos   = 6'(pos);
      kind        = model_click(pos, cyc);
      @(negedge clk);
      click_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every pulse must match the next scoreboard entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (move_done || move_illegal) begin
            if (expq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_pulse: done=%0b illegal=%0b, expected no pulse",
                        move_done, move_illegal);
            end else begin
               e = expq.pop_front();
               chk("pulse_kind", 256'({move_done, move_illegal}),
                   256'(e.is_done ? 2'b10 : 2'b01));
               chk("pulse_cycle", 256'(cyc), 256'(e.cyc));
               if (e.is_done) chk("captured_piece", 256'(captured_piece), 256'(e.cap));
               @(negedge clk);
               chk("board_after", board_flat, e.board);
               chk("turn_after", 256'(turn), 256'(e.turn));
            end
         end
      end
   end

   initial begin
      int k;
      int pos;
      int r;
      int cand[$];

      rst = 1'b1;
      click_valid = 1'b0;
      click_pos = '0;
      for (int i = 0; i < 64; i++) mask_tab[i] = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("reset_board", board_flat, tb_init);
      chk("reset_sq4", 256'(sq(4)), 256'(6));
      chk("reset_sq60", 256'(sq(60)), 256'(12));
      chk("reset_sq8", 256'(sq(8)), 256'(1));
      chk("reset_sq32", 256'(sq(32)), 256'(0));
      chk("reset_turn", 256'(turn), 256'(0));
      chk("reset_pulses", 256'({move_done, move_illegal}), 256'(0));
      chk("reset_captured", 256'(captured_piece), 256'(0));
      chk("reset_sel", 256'({sel_figure, sel_pos}), 256'(0));
      chk("reset_ready", 256'(click_ready), 256'(1));

      mask_tab[12] = (64'd1 << 20) | (64'd1 << 28);
      mask_tab[51] = 64'd1 << 35;
      mask_tab[28] = 64'd1 << 35;
      mask_tab[52] = 64'd1 << 36;

      // Black pawn clicked with white to move: dropped.
      do_click(52, k); idle(3);
      chk("foreign_ready", 256'(click_ready), 256'(1));
      chk("foreign_sel_pos", 256'(sel_pos), 256'(0));

      // Select, deselect, select another square.
      do_click(12, k); idle(3);
      chk("sel12_pos", 256'(sel_pos), 256'(12));
      chk("sel12_fig", 256'(sel_figure), 256'(1));
      do_click(12, k); idle(3);
      chk("desel_ready", 256'(click_ready), 256'(1));
      do_click(11, k);
      chk("select_busy", 256'(click_ready), 256'(0));
      chk("sel11_pos", 256'(sel_pos), 256'(11));
      chk("sel11_fig", 256'(sel_figure), 256'(1));
      idle(3);
      chk("armed_ready", 256'(click_ready), 256'(1));
      do_click(11, k); idle(3);

      // Illegal target, still armed, then the legal move.
      do_click(12, k); idle(3);
      do_click(44, k); idle(3);
      chk("illegal_armed", 256'(click_ready), 256'(1));
      chk("illegal_sel_kept", 256'(sel_pos), 256'(12));
      do_click(28, k); idle(3);
      chk("move_sq28", 256'(sq(28)), 256'(1));
      chk("move_sq12", 256'(sq(12)), 256'(0));
      chk("move_turn", 256'(turn), 256'(1));

      // Black pawn to 35, white pawn captures it.
      do_click(51, k); idle(3);
      do_click(35, k); idle(3);
      do_click(28, k); idle(3);
      do_click(35, k); idle(3);
      chk("capture_piece", 256'(captured_piece), 256'(7));
      chk("capture_sq35", 256'(sq(35)), 256'(1));

      // Black move interrupted by reset during the source-clear cycle.
      do_click(52, k); idle(3);
      click_valid = 1'b1;
      click_pos = 6'd36;
      @(negedge clk);
      click_valid = 1'b0;
      chk("clear_src_busy", 256'(click_ready), 256'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      expq.delete();
      chk("midreset_board", board_flat, tb_init);
      chk("midreset_turn", 256'(turn), 256'(0));
      chk("midreset_captured", 256'(captured_piece), 256'(0));
      chk("midreset_sel", 256'({sel_figure, sel_pos}), 256'(0));
      chk("midreset_ready", 256'(click_ready), 256'(1));
      idle(3);

      // Randomized play against the model.
      for (int i = 0; i < 64; i++)
         mask_tab[i] = {$urandom, $urandom} & {$urandom, $urandom};
      for (int n = 0; n < 400; n++) begin
         cand.delete();
         for (int i = 0; i < 64; i++)
            if (own(mboard[i], mturn)) cand.push_back(i);
         r = $urandom_range(0, 9);
         pos = $urandom_range(0, 63);
         if (r < 3 && cand.size() > 0) begin
            pos = cand[$urandom_range(0, cand.size() - 1)];
         end else if (r < 6 && msel_v) begin
            for (int t = 0; t < 8; t++) begin
               int j;
               j = $urandom_range(0, 63);
               if (mask_tab[msel][j]) begin
                  pos = j;
                  break;
               end
            end
         end
         do_click(pos, k);
         if (k == 3 && $urandom_range(0, 2) == 0) begin
            chk("stray_clear_src_ready", 256'(click_ready), 256'(0));
            click_valid = 1'b1;
            click_pos = 6'($urandom_range(0, 63));
            @(negedge clk);
            chk("stray_write_dst_ready", 256'(click_ready), 256'(0));
            click_valid = 1'b0;
         end
         idle(3);
         if (k == 1) begin
            chk("rand_sel_pos", 256'(sel_pos), 256'(msel));
            chk("rand_sel_fig", 256'(sel_figure), 256'(mboard[msel]));
         end
      end

      for (int t = 0; t < 20 && expq.size() != 0; t++) @(negedge clk);
      if (expq.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL missing_pulses: %0d outstanding, expected 0", expq.size());
      end
      chk("final_board", board_flat, model_flat());
      chk("final_turn", 256'(turn), 256'(mturn));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/move_commit_ctrl.md
MOVE_COMMIT_CTRL -- requirements
Module: move_commit_ctrl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port click_valid  input  1  one-cycle pulse: player clicked a square.
REQ-004 SHALL have port click_pos  input  6  clicked square: [2:0] column, [5:3] row.
REQ-005 SHALL have port click_ready  output  1  high only in IDLE and ARMED; clicks are ignored otherwise.
REQ-006 SHALL have port sel_figure  output  4  piece code of the selected source square, sent to the move-mask generator.
REQ-007 SHALL have port sel_pos  output  6  selected source square, sent to the move-mask generator.
REQ-008 SHALL have port possible_moves  input  64  legal-target mask from the generator; bit index = row*8+col; combinational from sel_figure, sel_pos and board.
REQ-009 SHALL have port board_flat  output  256  board state, 4 bits per square, square n at [4n+3:4n].
REQ-010 SHALL have port turn  output  1  side to move: 0 = white, 1 = black.
REQ-011 SHALL have port move_done  output  1  one-cycle pulse: a move was committed.
REQ-012 SHALL have port move_illegal  output  1  one-cycle pulse: the target click was rejected.
REQ-013 SHALL have port captured_piece  output  4  code of the piece removed by the last move; 0 if no capture.

Function
REQ-014 Piece codes SHALL be: 0 = empty; white 1..6 = pawn, bishop, knight, rook, queen, king; black 7..12 in the same order; 13..15 unused and treated as empty.
REQ-015 FSM states SHALL be IDLE, SELECT, ARMED, CLEAR_SRC, WRITE_DST.
REQ-016 IDLE: a click on a square holding a piece of the side to move SHALL latch sel_pos and sel_figure, then go to SELECT; any other click SHALL be dropped with no pulse.
REQ-017 SELECT SHALL last exactly one cycle, then register possible_moves into an internal mask and go to ARMED.
REQ-018 ARMED, click on dest == sel_pos: SHALL deselect, clear the mask and go to IDLE, with no pulse.
REQ-019 ARMED, click on another square holding a piece of the side to move: SHALL reselect that square and go to SELECT.
REQ-020 ARMED, click whose dest bit is set in the latched mask: SHALL latch dest and go to CLEAR_SRC.
REQ-021 ARMED, any other click: SHALL pulse move_illegal in the next cycle and stay in ARMED.
REQ-022 CLEAR_SRC SHALL write 0 to sel_pos and capture the old dest contents into captured_piece.
REQ-023 WRITE_DST SHALL write sel_figure to dest, pulse move_done, toggle turn, and return to IDLE.
REQ-024 Latency from accepted dest click to move_done SHALL be 2 cycles.
REQ-025 Only the FSM SHALL write the board, and it SHALL write at most one square per cycle.
REQ-026 A click_valid arriving while click_ready is low SHALL be discarded, not queued.
REQ-027 sel_figure and sel_pos SHALL hold stable from SELECT through WRITE_DST.

Reset
REQ-028 rst SHALL force: state IDLE, turn 0, all pulses 0, captured_piece 0, sel_figure 0, sel_pos 0, mask 0.
REQ-029 rst SHALL load the initial position:
- row 0: 4,3,2,5,6,2,3,4 (columns 0..7)
- row 1: all 1
- row 6: all 7
- row 7: 10,9,8,11,12,8,9,10
- all other squares 0
REQ-030 rst asserted mid-move, including in CLEAR_SRC, SHALL take priority and leave no partial board write.

Structure
REQ-031 A shared package chess_pkg SHALL hold the piece-code constants, the FSM state enum, the INIT_BOARD constant, and the helper is_side(piece, turn).
REQ-032 Board storage SHALL be a sub-module board_regfile: 64x4 registers, one write port, flat read-out, reset to INIT_BOARD.

Verification
REQ-033 Reset, then read board_flat: square 4 = 6, square 60 = 12, square 8 = 1, square 32 = 0; turn = 0.
REQ-034 Click 12, mask bits {20,28} set, click 28 -> move_done 2 cycles later; square 28 = 1; square 12 = 0; turn = 1.
REQ-035 Click 12, then click 44 with mask bit 44 clear -> move_illegal pulse; board unchanged; state ARMED.
REQ-036 White to move, click 52 (black pawn) -> no pulse; state stays IDLE.
REQ-037 Click 12, click 12 -> IDLE; then click 11 -> SELECT with sel_pos = 11 and sel_figure = 1.
REQ-038 Capture (square 35 = 7, mask bit 35 set), then assert rst during the following move's CLEAR_SRC -> captured_piece = 7 after the capture; after rst, board equals INIT_BOARD.
